// File: rtl/eth_stats_pkg.sv
// eth_stats_pkg: shared constants and types for the Ethernet receive statistics block.
//   - Default counter width and runt/oversize length thresholds.
//   - Receive framing state encoding.
//   - Index map of the live statistics counters.
//   - Saturating increment helper for the 16-bit per-frame length counter.
package eth_stats_pkg;

  localparam int unsigned DefCntWidth = 64;
  localparam int unsigned DefMinFrame = 60;
  localparam int unsigned DefMaxFrame = 1518;

  localparam int unsigned LenWidth = 16;

  // Live counter slots, shared by the top level and its counter array.
  localparam int unsigned CntGood  = 0;
  localparam int unsigned CntBad   = 1;
  localparam int unsigned CntFcs   = 2;
  localparam int unsigned CntRunt  = 3;
  localparam int unsigned CntOver  = 4;
  localparam int unsigned CntBytes = 5;
  localparam int unsigned NumCnt   = 6;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StInFrame = 1'b1
  } rx_state_e;

  function automatic logic [LenWidth-1:0] sat_inc(input logic [LenWidth-1:0] v);
    return (&v) ? v : v + LenWidth'(1);
  endfunction

endpackage

// File: rtl/eth_stats_counter.sv
// eth_stats_counter: one wrapping statistics counter.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset, clears the count
//   clr_i   - synchronous clear; an increment in the same cycle still lands
//   inc_i   - add val_i this cycle
//   val_i   - amount to add, zero-extended or truncated to Width
//   cnt_o   - current count, wraps modulo 2^Width
module eth_stats_counter #(
  parameter int unsigned Width    = 64,
  parameter int unsigned ValWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [ValWidth-1:0] val_i,
  output logic [Width-1:0]    cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;
  logic [Width-1:0] base, addend;

  always_comb begin
    base   = clr_i ? '0 : cnt_q;
    addend = inc_i ? Width'(val_i) : '0;
    cnt_d  = base + addend;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_stats.sv
// eth_rx_stats: passive statistics monitor on a MAC receive AXI-Stream (no tready).
//   clk, rst_n            - MAC rx clock, asynchronous active-low reset
//   rx_axis_t*            - monitored receive stream (tdata ignored, length only)
//   rx_error              - bit1 = bad-FCS pulse (counted); bit0 not counted
//   enable                - counting enable, captured on a frame's first beat
//   latch, clear          - snapshot live counters / zero live counters
//   frames_*, bytes_good  - snapshot registers, updated only by latch
//   in_frame              - high between a frame's first and last beat
module eth_rx_stats
  import eth_stats_pkg::*;
#(
  parameter int unsigned C_CNT_WIDTH = DefCntWidth,
  parameter int unsigned C_MAX_FRAME = DefMaxFrame,
  parameter int unsigned C_MIN_FRAME = DefMinFrame
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_axis_tdata,
  input  logic                   rx_axis_tvalid,
  input  logic                   rx_axis_tlast,
  input  logic                   rx_axis_tuser,
  input  logic [1:0]             rx_error,
  input  logic                   enable,
  input  logic                   latch,
  input  logic                   clear,
  output logic [C_CNT_WIDTH-1:0] frames_good,
  output logic [C_CNT_WIDTH-1:0] frames_bad,
  output logic [C_CNT_WIDTH-1:0] frames_fcs_err,
  output logic [C_CNT_WIDTH-1:0] frames_runt,
  output logic [C_CNT_WIDTH-1:0] frames_oversize,
  output logic [C_CNT_WIDTH-1:0] bytes_good,
  output logic                   in_frame
);

  localparam logic [LenWidth-1:0] MinLen = LenWidth'(C_MIN_FRAME);
  localparam logic [LenWidth-1:0] MaxLen = LenWidth'(C_MAX_FRAME);

  rx_state_e           state_d, state_q;
  logic [LenWidth-1:0] len_d, len_q;
  logic                en_d, en_q;

  logic [LenWidth-1:0] frame_len;
  logic                frame_en;
  logic                frame_done;
  logic                good_inc, bad_inc, runt_inc, over_inc, fcs_inc;

  logic [NumCnt-1:0]                  cnt_inc;
  logic [NumCnt-1:0][LenWidth-1:0]    cnt_val;
  logic [NumCnt-1:0][C_CNT_WIDTH-1:0] live;
  logic [NumCnt-1:0][C_CNT_WIDTH-1:0] snap_q;

  // Payload bytes and the bad-frame pulse carry no information the counters use.
  logic unused_inputs;
  assign unused_inputs = ^{rx_axis_tdata, rx_error[0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    en_d    = en_q;
    if (rx_axis_tvalid) begin
      len_d = rx_axis_tlast ? '0 : sat_inc(len_q);
      if (state_q == StIdle) begin
        en_d = enable;
      end
      case (state_q)
        StIdle:    if (!rx_axis_tlast) state_d = StInFrame;
        StInFrame: if (rx_axis_tlast) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      en_q    <= en_d;
    end
  end

  // A beat seen in IDLE is a frame's first beat, so its enable is the live input;
  // later beats use the value captured on that first beat.
  assign frame_en   = (state_q == StIdle) ? enable : en_q;
  assign frame_len  = sat_inc(len_q);
  assign frame_done = rx_axis_tvalid & rx_axis_tlast & frame_en;

  assign good_inc = frame_done & ~rx_axis_tuser;
  assign bad_inc  = frame_done & rx_axis_tuser;
  assign runt_inc = good_inc & (frame_len < MinLen);
  assign over_inc = good_inc & (frame_len > MaxLen);
  assign fcs_inc  = rx_error[1] & enable;

  always_comb begin
    cnt_inc           = '0;
    cnt_inc[CntGood]  = good_inc;
    cnt_inc[CntBad]   = bad_inc;
    cnt_inc[CntFcs]   = fcs_inc;
    cnt_inc[CntRunt]  = runt_inc;
    cnt_inc[CntOver]  = over_inc;
    cnt_inc[CntBytes] = good_inc;
    cnt_val           = {NumCnt{LenWidth'(1)}};
    cnt_val[CntBytes] = frame_len;
  end

  for (genvar i = 0; i < NumCnt; i++) begin : g_cnt
    eth_stats_counter #(
      .Width   (C_CNT_WIDTH),
      .ValWidth(LenWidth)
    ) u_cnt (
      .clk_i (clk),
      .rst_ni(rst_n),
      .clr_i (clear),
      .inc_i (cnt_inc[i]),
      .val_i (cnt_val[i]),
      .cnt_o (live[i])
    );
  end

  // Snapshot takes the pre-edge live values, so a frame finishing or a clear
  // landing in the latch cycle is not reflected in that snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (latch) begin
      snap_q <= live;
    end
  end

  assign frames_good     = snap_q[CntGood];
  assign frames_bad      = snap_q[CntBad];
  assign frames_fcs_err  = snap_q[CntFcs];
  assign frames_runt     = snap_q[CntRunt];
  assign frames_oversize = snap_q[CntOver];
  assign bytes_good      = snap_q[CntBytes];
  assign in_frame        = (state_q == StInFrame);

endmodule

// File: tb/tb_eth_rx_stats.sv
// tb_eth_rx_stats: directed stimulus with a snapshot scoreboard. Each latch request
// pushes the hand-computed expected snapshot; a monitor pops and compares in the
// cycle after latch. A second instance with 4-bit counters checks wrap-around.
module tb_eth_rx_stats;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser;
  logic [1:0] rx_error;
  logic       enable, latch, clear;

  logic [63:0] frames_good, frames_bad, frames_fcs_err, frames_runt, frames_oversize;
  logic [63:0] bytes_good;
  logic        in_frame;

  logic [3:0] n4_good, n4_bad, n4_fcs, n4_runt, n4_over, n4_bytes;
  logic       n4_in_frame;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] good, bad, fcs, runt, over, bytes;
    logic [3:0]  good4, bytes4;
  } snap_t;

  snap_t exp_q[$];
  logic  latch_d;

  always #5 clk = ~clk;

  eth_rx_stats dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_axis_tdata  (tdata),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tlast  (tlast),
    .rx_axis_tuser  (tuser),
    .rx_error       (rx_error),
    .enable         (enable),
    .latch          (latch),
    .clear          (clear),
    .frames_good    (frames_good),
    .frames_bad     (frames_bad),
    .frames_fcs_err (frames_fcs_err),
    .frames_runt    (frames_runt),
    .frames_oversize(frames_oversize),
    .bytes_good     (bytes_good),
    .in_frame       (in_frame)
  );

  eth_rx_stats #(
    .C_CNT_WIDTH(4)
  ) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_axis_tdata  (tdata),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tlast  (tlast),
    .rx_axis_tuser  (tuser),
    .rx_error       (rx_error),
    .enable         (enable),
    .latch          (latch),
    .clear          (clear),
    .frames_good    (n4_good),
    .frames_bad     (n4_bad),
    .frames_fcs_err (n4_fcs),
    .frames_runt    (n4_runt),
    .frames_oversize(n4_over),
    .bytes_good     (n4_bytes),
    .in_frame       (n4_in_frame)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] good, input logic [63:0] bad,
                          input logic [63:0] fcs, input logic [63:0] runt,
                          input logic [63:0] over, input logic [63:0] bytes,
                          input logic [3:0] good4, input logic [3:0] bytes4);
    snap_t s;
    s.good = good; s.bad = bad; s.fcs = fcs; s.runt = runt; s.over = over;
    s.bytes = bytes; s.good4 = good4; s.bytes4 = bytes4;
    exp_q.push_back(s);
  endtask

  // Snapshot registers update on the edge that sees latch; check half a cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_d <= 1'b0;
    else        latch_d <= latch;
  end

  always @(negedge clk) begin
    if (latch_d) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL snapshot_unexpected: got latch with no expectation, required none");
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        chk("frames_good", frames_good, e.good);
        chk("frames_bad", frames_bad, e.bad);
        chk("frames_fcs_err", frames_fcs_err, e.fcs);
        chk("frames_runt", frames_runt, e.runt);
        chk("frames_oversize", frames_oversize, e.over);
        chk("bytes_good", bytes_good, e.bytes);
        chk("n4_frames_good", 64'(n4_good), 64'(e.good4));
        chk("n4_bytes_good", 64'(n4_bytes), 64'(e.bytes4));
      end
    end
  end

  // Drive len beats; tlast on the final one if term. flip_at toggles enable at that beat.
  task automatic send(input int len, input bit term, input bit user, input bit lc,
                      input int flip_at);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 1) chk("in_frame_mid", 64'(in_frame), 64'd1);
      if (i == flip_at) enable = ~enable;
      tvalid = 1'b1;
      tdata  = 8'($urandom);
      tlast  = term && (i == len - 1);
      tuser  = tlast && user;
      if (lc && tlast) begin
        latch = 1'b1;
        clear = 1'b1;
      end
    end
    if (term) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      latch  = 1'b0;
      clear  = 1'b0;
      chk("in_frame_end", 64'(in_frame), 64'd0);
    end
  endtask

  task automatic do_latch(input logic [63:0] good, input logic [63:0] bad,
                          input logic [63:0] fcs, input logic [63:0] runt,
                          input logic [63:0] over, input logic [63:0] bytes,
                          input logic [3:0] good4, input logic [3:0] bytes4);
    push_exp(good, bad, fcs, runt, over, bytes, good4, bytes4);
    @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    rx_error = 2'b00; enable = 1'b1; latch = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_frame", 64'(in_frame), 64'd0);
    chk("rst_frames_good", frames_good, 64'd0);
    chk("rst_bytes_good", bytes_good, 64'd0);
    rst_n = 1'b1;

    // Three 64-byte good frames.
    repeat (3) send(64, 1, 0, 0, -1);
    do_latch(3, 0, 0, 0, 0, 192, 3, 0);
    do_clear();

    // Runt and oversize.
    send(40, 1, 0, 0, -1);
    send(2000, 1, 0, 0, -1);
    do_latch(2, 0, 0, 1, 1, 2040, 2, 8);
    do_clear();

    // Bad frame plus FCS pulses; the one with enable low must not count.
    @(negedge clk) rx_error = 2'b11;
    @(negedge clk) rx_error = 2'b00; enable = 1'b0;
    @(negedge clk) rx_error = 2'b10;
    @(negedge clk) rx_error = 2'b00; enable = 1'b1;
    send(100, 1, 1, 0, -1);
    do_latch(0, 1, 1, 0, 0, 0, 0, 0);
    do_clear();

    // Five frames, then latch+clear on the sixth frame's tlast.
    repeat (5) send(64, 1, 0, 0, -1);
    push_exp(5, 0, 0, 0, 0, 320, 5, 0);
    send(64, 1, 0, 1, -1);
    do_latch(1, 0, 0, 0, 0, 64, 1, 0);
    do_clear();

    // Enable changes mid-frame are ignored in both directions.
    send(64, 1, 0, 0, 10);
    send(64, 1, 0, 0, 20);
    do_latch(1, 0, 0, 0, 0, 64, 1, 0);
    do_clear();

    // 17 minimum-length frames: 60 is not a runt; 4-bit copy wraps to 1.
    repeat (17) send(60, 1, 0, 0, -1);
    do_latch(17, 0, 0, 0, 0, 1020, 1, 12);
    do_clear();

    // Reset after 30 beats; the 34 beats that follow form a new runt frame.
    send(30, 0, 0, 0, -1);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_in_frame", 64'(in_frame), 64'd0);
    chk("mid_rst_frames_good", frames_good, 64'd0);
    chk("mid_rst_bytes_good", bytes_good, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(34, 1, 0, 0, -1);
    do_latch(1, 0, 0, 1, 0, 34, 1, 2);
    do_clear();

    // Length boundaries and a single-beat frame.
    send(1518, 1, 0, 0, -1);
    send(1519, 1, 0, 0, -1);
    send(59, 1, 0, 0, -1);
    send(1, 1, 0, 0, -1);
    do_latch(4, 0, 0, 2, 1, 3097, 4, 9);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_rx_stats.md
ETH_RX_STATS -- requirements
Module: eth_rx_stats

Interface
REQ-001 The block SHALL have parameter C_CNT_WIDTH, default 64, meaning the width of every statistics counter.
REQ-002 The block SHALL have parameter C_MAX_FRAME, default 1518, meaning the largest byte length (FCS stripped, as delivered) classed as non-oversize.
REQ-003 The block SHALL have parameter C_MIN_FRAME, default 60, meaning the smallest byte length classed as non-runt.
REQ-004 Port clk  in  1  the single clock, the MAC rx_clk domain.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports rx_axis_tdata/tvalid/tlast/tuser  in  8/1/1/1  monitored MAC receive stream, no tready; the block never backpressures.
REQ-007 Port rx_error  in  2  MAC pulses: bit0 bad frame, bit1 bad FCS.
REQ-008 Port enable  in  1  counting enable, sampled on the first beat of each frame.
REQ-009 Ports latch, clear  in  1 each  single-cycle snapshot and clear requests.
REQ-010 Ports frames_good, frames_bad, frames_fcs_err, frames_runt, frames_oversize, bytes_good  out  C_CNT_WIDTH each  snapshot registers.
REQ-011 Port in_frame  out  1  high while a frame is in progress.

Function
REQ-012 Two states: IDLE and IN_FRAME; IDLE->IN_FRAME on tvalid without tlast; IN_FRAME->IDLE on tvalid with tlast; a tvalid&tlast beat in IDLE is a complete 1-byte frame with no state change.
REQ-013 in_frame SHALL equal (state==IN_FRAME), registered, zero latency beyond the state register.
REQ-014 A 16-bit per-frame length counter SHALL increment on each tvalid beat, saturate at 0xFFFF, and reset to 0 after each tlast beat.
REQ-015 Frame length at tlast SHALL be counter+1 (saturating); classification uses this value.
REQ-016 The enable value sampled on a frame's first beat SHALL govern all counting for that whole frame; enable changes mid-frame are ignored.
REQ-017 On tlast with tuser=0: frames_good live counter +1, bytes_good live counter + length; additionally runt +1 if length<C_MIN_FRAME, oversize +1 if length>C_MAX_FRAME.
REQ-018 On tlast with tuser=1: frames_bad live counter +1, no byte accumulation.
REQ-019 frames_fcs_err live counter SHALL increment on every rx_error[1] pulse regardless of frame state, gated by current enable.
REQ-020 All live counters SHALL wrap modulo 2^C_CNT_WIDTH; no saturation, no overflow flag.
REQ-021 latch SHALL copy all live counters to the output registers on the next edge (1-cycle latency); outputs hold otherwise.
REQ-022 A frame completing in the same cycle as latch SHALL be excluded from that snapshot and included in live counters.
REQ-023 clear SHALL zero all live counters on the next edge; outputs unaffected.
REQ-024 latch and clear together: snapshot captures pre-clear live values, live counters become zero.
REQ-025 clear coincident with a frame completion: live counters SHALL end at that frame's increments (e.g. frames_good=1), not zero.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, length counter 0, all live counters 0, all outputs 0, in_frame 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; remaining beats up to tlast after release SHALL be treated as a new frame from the first tvalid beat.

Structure
REQ-028 Package eth_stats_pkg SHALL hold the default C_CNT_WIDTH, C_MIN_FRAME, C_MAX_FRAME constants and the IDLE/IN_FRAME state encoding.
REQ-029 One sub-module eth_stats_counter (inc, add value, clear, wrap, async reset) SHALL be instantiated per live counter.

Verification
REQ-030 Three 64-byte good frames, enable=1, then latch -> frames_good=3, bytes_good=192, others 0, in_frame low after each tlast.
REQ-031 40-byte good frame and 2000-byte good frame -> frames_runt=1, frames_oversize=1, frames_good=2, bytes_good=2040.
REQ-032 100-byte frame with tuser=1 on tlast and rx_error=2'b11 pulse -> frames_bad=1, frames_fcs_err=1, bytes_good unchanged.
REQ-033 latch+clear in same cycle as a good 64-byte tlast after 5 prior frames -> snapshot frames_good=5; second latch -> frames_good=1, bytes_good=64.
REQ-034 enable dropped mid-frame of enabled frame, then frame starting with enable=0 -> first counted, second not; C_CNT_WIDTH=4 with 17 frames -> frames_good=1.
REQ-035 rst_n asserted at byte 30 of a frame, released, remaining 34 beats with tlast -> frames_runt=1, length 34 classified.
